// File: rtl/obi_pkg.sv
// Shared OBI definitions: manager FSM state encoding and default bus widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package obi_pkg;

    localparam int OBI_ADDR_W = 32;
    localparam int OBI_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } obi_state_e;

endpackage : obi_pkg

// File: rtl/obi_manager_if.sv
// Bundle of the controller command/response channels and the OBI A/R channels.
// Latency: n/a (wires only).
// Backpressure: cmd valid/ready, rsp valid/ready, OBI req/gnt and rvalid/rready.
// Modports: master = the obi_manager side, slave = controller plus OBI subordinate side.
interface obi_manager_if
    import obi_pkg::*;
#(
    parameter int ADDR_WIDTH = OBI_ADDR_W,
    parameter int DATA_WIDTH = OBI_DATA_W
);
    // controller command channel
    logic                    cmd_valid_i;
    logic                    cmd_ready_o;
    logic                    cmd_we_i;
    logic [ADDR_WIDTH-1:0]   cmd_addr_i;
    logic [DATA_WIDTH/8-1:0] cmd_be_i;
    logic [DATA_WIDTH-1:0]   cmd_wdata_i;
    // controller response channel
    logic                    rsp_valid_o;
    logic                    rsp_ready_i;
    logic [DATA_WIDTH-1:0]   rsp_rdata_o;
    logic                    rsp_err_o;
    // OBI A channel
    logic                    obi_req_o;
    logic                    obi_gnt_i;
    logic [ADDR_WIDTH-1:0]   obi_addr_o;
    logic                    obi_we_o;
    logic [DATA_WIDTH/8-1:0] obi_be_o;
    logic [DATA_WIDTH-1:0]   obi_wdata_o;
    // OBI R channel
    logic                    obi_rvalid_i;
    logic                    obi_rready_o;
    logic [DATA_WIDTH-1:0]   obi_rdata_i;
    logic                    obi_err_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_be_i, cmd_wdata_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  rsp_ready_i,
        output obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
        input  obi_gnt_i,
        input  obi_rvalid_i, obi_rdata_i, obi_err_i,
        output obi_rready_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_be_i, cmd_wdata_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output rsp_ready_i,
        input  obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o,
        output obi_gnt_i,
        output obi_rvalid_i, obi_rdata_i, obi_err_i,
        input  obi_rready_o
    );

endinterface : obi_manager_if

// File: rtl/obi_mgr_timer.sv
// Response-wait watchdog: counts enabled cycles, flags the CYCLES-th one as expired.
// Latency: expired is combinational on the current count (asserted in the CYCLES-th enabled cycle).
// Backpressure: none; holds its count while disabled, clear has priority over counting.
// Ports: clk_i, reset_ni, enable (count this cycle), clear (restart at 0), expired.
module obi_mgr_timer #(
    parameter int CYCLES = 256
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] cnt_q;

    // cnt_q holds (enabled cycles seen - 1) during an enabled cycle, so the
    // CYCLES-th enabled cycle is the one where cnt_q reaches CYCLES-1.
    assign expired = enable && (cnt_q == CW'(CYCLES - 1));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule : obi_mgr_timer

// File: rtl/obi_manager.sv
// Single-outstanding OBI manager: turns one controller command into one OBI A/R transaction.
// Latency: rsp_valid_o rises 3 cycles after the accept cycle when gnt and rvalid come immediately.
// Backpressure: cmd_ready_o only in IDLE; req held until gnt; response held until rsp_ready_i.
// Ports: clk_i, reset_ni (async, active low), bus (obi_manager_if.master).
// Optional: define OBI_MGR_TIMEOUT_EN to bound the response wait to TIMEOUT_CYCLES
// (error response with zero data); the grant wait is never bounded.
module obi_manager
    import obi_pkg::*;
#(
    parameter int ADDR_WIDTH     = OBI_ADDR_W,
    parameter int DATA_WIDTH     = OBI_DATA_W,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    obi_manager_if.master bus
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    // Elaboration-time guard on the configuration.
    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64) || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("obi_manager: DATA_WIDTH must be 32 or 64 and TIMEOUT_CYCLES >= 1");
    end

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [BE_WIDTH-1:0]   be;
        logic [DATA_WIDTH-1:0] wdata;
    } a_chan_t;

    obi_state_e            state_q;
    a_chan_t               a_q;
    logic                  cmd_rdy_q;
    logic                  req_q;
    logic                  rready_q;
    logic                  rsp_vld_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

`ifdef OBI_MGR_TIMEOUT_EN
    logic tmr_expired;

    // Restart on the ADDR->RESP transition so every RESP phase gets a full budget.
    obi_mgr_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .enable   (state_q == RESP),
        .clear    ((state_q == ADDR) && bus.obi_gnt_i),
        .expired  (tmr_expired)
    );
`endif

    // All outputs come straight from flops updated together with the state.
    // cmd_rdy_q resets to 0 and rises on the first clock in IDLE after release,
    // so nothing is accepted during or on the very edge of reset release.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            a_q       <= '0;
            cmd_rdy_q <= 1'b0;
            req_q     <= 1'b0;
            rready_q  <= 1'b0;
            rsp_vld_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cmd_rdy_q <= 1'b1;
                    if (bus.cmd_valid_i && cmd_rdy_q) begin
                        a_q       <= '{we:    bus.cmd_we_i,
                                       addr:  bus.cmd_addr_i,
                                       be:    bus.cmd_be_i,
                                       wdata: bus.cmd_wdata_i};
                        cmd_rdy_q <= 1'b0;
                        req_q     <= 1'b1;
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    // No abort path here: OBI forbids dropping req before gnt.
                    if (bus.obi_gnt_i) begin
                        req_q    <= 1'b0;
                        rready_q <= 1'b1;
                        state_q  <= RESP;
                    end
                end
                RESP: begin
                    // A real response wins over a timeout landing in the same cycle.
                    if (bus.obi_rvalid_i) begin
                        rdata_q   <= bus.obi_rdata_i;
                        err_q     <= bus.obi_err_i;
                        rready_q  <= 1'b0;
                        rsp_vld_q <= 1'b1;
                        state_q   <= DONE;
                    end
`ifdef OBI_MGR_TIMEOUT_EN
                    else if (tmr_expired) begin
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                        rready_q  <= 1'b0;
                        rsp_vld_q <= 1'b1;
                        state_q   <= DONE;
                    end
`endif
                end
                DONE: begin
                    if (bus.rsp_ready_i) begin
                        rsp_vld_q <= 1'b0;
                        cmd_rdy_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready_o  = cmd_rdy_q;
    assign bus.obi_req_o    = req_q;
    assign bus.obi_addr_o   = a_q.addr;
    assign bus.obi_we_o     = a_q.we;
    assign bus.obi_be_o     = a_q.be;
    assign bus.obi_wdata_o  = a_q.wdata;
    assign bus.obi_rready_o = rready_q;
    assign bus.rsp_valid_o  = rsp_vld_q;
    assign bus.rsp_rdata_o  = rdata_q;
    assign bus.rsp_err_o    = err_q;

endmodule : obi_manager

// File: tb/tb_obi_manager.sv
// Self-checking bench for obi_manager: directed scenarios plus randomized transactions.
// Latency: n/a.
// Backpressure: the bench plays controller and subordinate, stalling gnt, rvalid and rsp_ready.
module tb_obi_manager;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    obi_manager_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    obi_manager #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .bus      (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; outputs are then sampled and inputs driven 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_req"},       bus.obi_req_o,    1'b0);
        check_eq({tag, "_rready"},    bus.obi_rready_o, 1'b0);
        check_eq({tag, "_rsp_valid"}, bus.rsp_valid_o,  1'b0);
    endtask

    // Reference behaviour: a command is accepted in an IDLE cycle, presented on
    // the A channel until granted (gnt_dly stall cycles), waits rv_dly cycles for
    // rvalid (or, with the timeout built in, gives up after TO response cycles
    // with err=1/data=0), then is held until rsp_ready (rdy_dly stall cycles).
    task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [BW-1:0] be,
                           input logic [DW-1:0] wdata, input int gnt_dly, input int rv_dly,
                           input int rdy_dly, input logic [DW-1:0] rdata, input logic err,
                           input bit spurious);
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        bit            timed_out;
        int            resp_cycles;

        check_eq("idle_cmd_ready", bus.cmd_ready_o, 1'b1);
        check_quiet("idle");
        bus.cmd_valid_i  = 1'b1;
        bus.cmd_we_i     = we;
        bus.cmd_addr_i   = addr;
        bus.cmd_be_i     = be;
        bus.cmd_wdata_i  = wdata;
        bus.obi_rvalid_i = spurious;
        bus.obi_rdata_i  = $urandom;
        step();
        // scramble the command payload: the A channel must keep the captured copy
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'($urandom);
        bus.cmd_addr_i  = $urandom;
        bus.cmd_be_i    = BW'($urandom);
        bus.cmd_wdata_i = $urandom;

        for (int k = 0; k <= gnt_dly; k++) begin
            check_eq("addr_req",       bus.obi_req_o,    1'b1);
            check_eq("addr_addr",      bus.obi_addr_o,   addr);
            check_eq("addr_we",        bus.obi_we_o,     we);
            check_eq("addr_be",        bus.obi_be_o,     be);
            check_eq("addr_wdata",     bus.obi_wdata_o,  wdata);
            check_eq("addr_rready",    bus.obi_rready_o, 1'b0);
            check_eq("addr_cmd_ready", bus.cmd_ready_o,  1'b0);
            check_eq("addr_rsp_valid", bus.rsp_valid_o,  1'b0);
            bus.obi_gnt_i    = (k == gnt_dly);
            bus.obi_rvalid_i = spurious;
            bus.obi_rdata_i  = $urandom;
            step();
        end
        bus.obi_gnt_i    = 1'b0;
        bus.obi_rvalid_i = 1'b0;

        timed_out = 1'b0;
`ifdef OBI_MGR_TIMEOUT_EN
        timed_out = (rv_dly >= TO);
`endif
        resp_cycles = timed_out ? TO : rv_dly + 1;
        exp_rdata   = timed_out ? '0 : rdata;
        exp_err     = timed_out ? 1'b1 : err;

        for (int k = 0; k < resp_cycles; k++) begin
            check_eq("resp_req",       bus.obi_req_o,    1'b0);
            check_eq("resp_rready",    bus.obi_rready_o, 1'b1);
            check_eq("resp_rsp_valid", bus.rsp_valid_o,  1'b0);
            if (!timed_out && k == rv_dly) begin
                bus.obi_rvalid_i = 1'b1;
                bus.obi_rdata_i  = rdata;
                bus.obi_err_i    = err;
            end else begin
                bus.obi_rvalid_i = 1'b0;
                bus.obi_rdata_i  = $urandom;
                bus.obi_err_i    = 1'($urandom);
            end
            step();
        end
        bus.obi_rvalid_i = 1'b0;
        bus.obi_err_i    = 1'b0;

        for (int k = 0; k <= rdy_dly; k++) begin
            check_eq("done_rsp_valid", bus.rsp_valid_o,  1'b1);
            check_eq("done_rdata",     bus.rsp_rdata_o,  exp_rdata);
            check_eq("done_err",       bus.rsp_err_o,    exp_err);
            check_eq("done_cmd_ready", bus.cmd_ready_o,  1'b0);
            check_eq("done_rready",    bus.obi_rready_o, 1'b0);
            check_eq("done_req",       bus.obi_req_o,    1'b0);
            bus.rsp_ready_i = (k == rdy_dly);
            step();
        end
        bus.rsp_ready_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_cmd_ready"}, bus.cmd_ready_o, 1'b0);
        check_quiet(tag);
        check_eq({tag, "_rdata"},     bus.rsp_rdata_o, '0);
        check_eq({tag, "_err"},       bus.rsp_err_o,   1'b0);
        check_eq({tag, "_addr"},      bus.obi_addr_o,  '0);
        check_eq({tag, "_we"},        bus.obi_we_o,    1'b0);
        check_eq({tag, "_be"},        bus.obi_be_o,    '0);
        check_eq({tag, "_wdata"},     bus.obi_wdata_o, '0);
    endtask

    initial begin
        bus.cmd_valid_i  = 1'b0;
        bus.cmd_we_i     = 1'b0;
        bus.cmd_addr_i   = '0;
        bus.cmd_be_i     = '0;
        bus.cmd_wdata_i  = '0;
        bus.rsp_ready_i  = 1'b0;
        bus.obi_gnt_i    = 1'b0;
        bus.obi_rvalid_i = 1'b0;
        bus.obi_rdata_i  = '0;
        bus.obi_err_i    = 1'b0;

        // reset state
        #1;
        check_reset_outputs("reset");
        step();
        step();
        reset_n = 1'b1;
        step();

        // read, zero wait states
        run_txn(1'b0, 32'h10, 4'hF, 32'h0, 0, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        // write with 4 grant stall cycles, rdata passed through unmodified
        run_txn(1'b1, 32'h20, 4'hF, 32'hA5A5_A5A5, 4, 0, 0, 32'h1234_5678, 1'b0, 1'b0);
        // error response held under 3 cycles of rsp_ready backpressure
        run_txn(1'b0, 32'h30, 4'h3, 32'h0, 0, 0, 3, 32'hCAFE_F00D, 1'b1, 1'b0);

        // spurious rvalid while IDLE, then during ADDR and the accept cycle
        for (int k = 0; k < 3; k++) begin
            bus.obi_rvalid_i = 1'b1;
            bus.obi_rdata_i  = $urandom;
            bus.obi_err_i    = 1'b1;
            step();
            check_eq("spur_idle_cmd_ready", bus.cmd_ready_o, 1'b1);
            check_quiet("spur_idle");
        end
        bus.obi_rvalid_i = 1'b0;
        bus.obi_err_i    = 1'b0;
        run_txn(1'b0, 32'h44, 4'hF, 32'h0, 2, 1, 0, 32'h0BAD_CAFE, 1'b0, 1'b1);

`ifdef OBI_MGR_TIMEOUT_EN
        // silent subordinate: error response after TO response cycles
        run_txn(1'b0, 32'h50, 4'hF, 32'h0, 1, TO, 1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        // rvalid in the last response cycle beats the timeout
        run_txn(1'b0, 32'h54, 4'hF, 32'h0, 0, TO - 1, 0, 32'h7777_1111, 1'b0, 1'b0);
`endif

        // randomized back-to-back traffic
        for (int n = 0; n < 40; n++) begin
            run_txn(1'($urandom), $urandom, BW'($urandom), $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                    int'($urandom_range(0, 2)), $urandom, 1'($urandom),
                    1'($urandom));
        end

        // reset asserted in the middle of RESP
        bus.cmd_valid_i = 1'b1;
        bus.cmd_addr_i  = 32'h60;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_be_i    = 4'hF;
        step();
        bus.cmd_valid_i = 1'b0;
        bus.obi_gnt_i   = 1'b1;
        step();
        bus.obi_gnt_i   = 1'b0;
        check_eq("mid_resp_rready", bus.obi_rready_o, 1'b1);
        step();
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        step();
        check_reset_outputs("mid_reset_held");
        reset_n = 1'b1;
        step();
        check_eq("post_reset_cmd_ready", bus.cmd_ready_o, 1'b1);
        for (int k = 0; k < 3; k++) begin
            bus.obi_rvalid_i = 1'b1;
            bus.obi_rdata_i  = 32'hBEEF_0000 + k;
            step();
            check_quiet("post_reset_rvalid");
            check_eq("post_reset_rdata", bus.rsp_rdata_o, '0);
        end
        bus.obi_rvalid_i = 1'b0;
        run_txn(1'b1, 32'h70, 4'h5, 32'h5555_AAAA, 1, 2, 1, 32'h2468_ACE0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule : tb_obi_manager

// File: doc/obi_manager.md
OBI_MANAGER -- requirements
Module: obi_manager

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: OBI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32 (32 or 64): OBI data width; BE width = DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256: response-wait limit, used only when the macro is defined.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk_i  in  1  clock (rising edge); reset_ni  in  1  reset.
REQ-005 SHALL have cmd_valid_i  in  1 (command offered); cmd_ready_o  out  1 (command accepted).
REQ-006 SHALL have cmd_we_i  in  1; cmd_addr_i  in  ADDR_WIDTH; cmd_be_i  in  DATA_WIDTH/8; cmd_wdata_i  in  DATA_WIDTH (command payload).
REQ-007 SHALL have rsp_valid_o  out  1; rsp_ready_i  in  1; rsp_rdata_o  out  DATA_WIDTH; rsp_err_o  out  1 (response to controller).
REQ-008 SHALL have obi_req_o  out  1; obi_gnt_i  in  1; obi_addr_o  out  ADDR_WIDTH; obi_we_o  out  1; obi_be_o  out  DATA_WIDTH/8; obi_wdata_o  out  DATA_WIDTH (OBI A channel).
REQ-009 SHALL have obi_rvalid_i  in  1; obi_rready_o  out  1; obi_rdata_i  in  DATA_WIDTH; obi_err_i  in  1 (OBI R channel).

Function
REQ-010 SHALL implement FSM states IDLE, ADDR, RESP, DONE; one transaction outstanding at most.
REQ-011 cmd_ready_o SHALL be 1 only in IDLE; cmd accepted when cmd_valid_i && cmd_ready_o; payload registered into A-channel regs; next state ADDR.
REQ-012 In ADDR, obi_req_o SHALL be 1 with registered addr/we/be/wdata held stable until obi_gnt_i=1; obi_req_o SHALL never drop before grant.
REQ-013 On obi_gnt_i=1 in ADDR, SHALL go to RESP next cycle and deassert obi_req_o.
REQ-014 obi_rready_o SHALL be 1 only in RESP; obi_rvalid_i in any other state SHALL be ignored (no capture, no state change).
REQ-015 On obi_rvalid_i=1 in RESP, SHALL capture obi_rdata_i into rsp_rdata_o and obi_err_i into rsp_err_o, go to DONE.
REQ-016 In DONE, rsp_valid_o SHALL be 1 with rsp_rdata_o/rsp_err_o stable until rsp_ready_i=1; then go to IDLE.
REQ-017 Minimum latency SHALL be 3 cycles from command-accept edge to rsp_valid_o=1 (gnt in first ADDR cycle, rvalid in first RESP cycle).
REQ-018 Writes SHALL return the subordinate's rdata unmodified in rsp_rdata_o (content not interpreted).
REQ-019 Back-to-back: a new command SHALL be accepted no earlier than the cycle after the DONE handshake (IDLE cycle).

Reset
REQ-020 reset_ni=0 SHALL immediately force state IDLE and all outputs 0 except cmd_ready_o, which SHALL be 1 after release; A-channel and response regs cleared to 0.
REQ-021 Reset asserted mid-transaction SHALL abandon it; no response SHALL be issued for it after release.

Configuration
REQ-022 With OBI_MGR_TIMEOUT_EN defined, a counter SHALL count cycles in RESP; at TIMEOUT_CYCLES without obi_rvalid_i, SHALL go to DONE with rsp_err_o=1, rsp_rdata_o=0; counter cleared on entering RESP.
REQ-023 OBI_MGR_TIMEOUT_EN SHALL never abort ADDR (grant wait unbounded, per OBI req stability rule).
REQ-024 Without OBI_MGR_TIMEOUT_EN, no counter logic SHALL exist; RESP waits indefinitely; TIMEOUT_CYCLES unused.
REQ-025 obi_rvalid_i and timeout expiring in the same cycle SHALL resolve to the rvalid capture (no error).

Structure
REQ-026 Shared package obi_pkg SHALL hold the FSM state enum type and default width constants (32-bit addr/data).
REQ-027 The timeout counter SHALL be a sub-module obi_mgr_timer (enable, clear, expired), instantiated only under OBI_MGR_TIMEOUT_EN.

Verification
REQ-028 Read: cmd addr=0x10, we=0; gnt in 1st ADDR cycle; rvalid next cycle with rdata=0xDEADBEEF -> rsp_valid_o 3 cycles after accept, rsp_rdata_o=0xDEADBEEF, rsp_err_o=0.
REQ-029 Write with grant stall: cmd we=1, addr=0x20, be=0xF, wdata=0xA5A5A5A5; gnt held low 4 cycles -> obi_req_o high and A-channel stable all 5 cycles; single response.
REQ-030 Error + response backpressure: obi_err_i=1 with rvalid; rsp_ready_i low 3 cycles -> rsp_valid_o/rsp_err_o=1 held stable 4 cycles; cmd_ready_o=0 throughout.
REQ-031 Spurious rvalid: obi_rvalid_i=1 in IDLE and during ADDR -> no state change, obi_rready_o=0, no rsp_valid_o.
REQ-032 Reset mid-RESP: reset_ni low 1 cycle -> all outputs 0 during reset, cmd_ready_o=1 after, later rvalid ignored.
REQ-033 With OBI_MGR_TIMEOUT_EN, TIMEOUT_CYCLES=8: no rvalid after gnt -> rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0 after 8 RESP cycles.
